// File: rtl/ttl_pkg.sv
// ttl_pkg: types and constants shared by the TTL-style register models.
// Contents:
//   MODE_W      width of the per-channel operation select
//   ttl_mode_e  the eight synchronous operations of the universal register
package ttl_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD = 3'b000,  // keep contents
        MODE_LOAD = 3'b001,  // parallel load from d
        MODE_SHR  = 3'b010,  // shift right, ser_r enters the MSB
        MODE_SHL  = 3'b011,  // shift left, ser_l enters the LSB
        MODE_INC  = 3'b100,  // count up, wraps mod 2^WIDTH
        MODE_DEC  = 3'b101,  // count down, wraps mod 2^WIDTH
        MODE_INV  = 3'b110,  // bitwise complement
        MODE_SCLR = 3'b111   // synchronous clear
    } ttl_mode_e;

endpackage

// File: rtl/ttl_univ_reg_ch.sv
// ttl_univ_reg_ch: one WIDTH-bit channel of the universal register.
// Ports:
//   clk       rising-edge clock
//   clr_n_i   async active-low clear (dominates preset)
//   pr_n_i    async active-low preset to PRESET_VAL
//   en_i      synchronous clock enable
//   mode_i    operation select (ttl_mode_e encoding)
//   d_i       parallel load data
//   ser_r_i   serial input for shift-right (enters MSB)
//   ser_l_i   serial input for shift-left (enters LSB)
//   q_o       register contents, with 74LS74-style async overrides
//   q_n_o     complement output (all ones with q_o when clear and preset overlap)
//   tc_o      terminal count, combinational, forced low while held async
module ttl_univ_reg_ch
    import ttl_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
    input  logic              clk,
    input  logic              clr_n_i,
    input  logic              pr_n_i,
    input  logic              en_i,
    input  logic [MODE_W-1:0] mode_i,
    input  logic [WIDTH-1:0]  d_i,
    input  logic              ser_r_i,
    input  logic              ser_l_i,
    output logic [WIDTH-1:0]  q_o,
    output logic [WIDTH-1:0]  q_n_o,
    output logic              tc_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    ttl_mode_e        mode;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             async_hold;

    assign mode       = ttl_mode_e'(mode_i);
    assign async_hold = !clr_n_i || !pr_n_i;

    always_comb begin
        // NOTE: next state defaults to the current state before the case, so
        // every path assigns q_d and no latch is inferred.
        q_d = q_q;
        if (en_i) begin
            case (mode)
                MODE_HOLD: q_d = q_q;
                MODE_LOAD: q_d = d_i;
                MODE_SHR:  q_d = {ser_r_i, q_q[WIDTH-1:1]};
                MODE_SHL:  q_d = {q_q[WIDTH-2:0], ser_l_i};
                MODE_INC:  q_d = q_q + ONE;
                MODE_DEC:  q_d = q_q - ONE;
                MODE_INV:  q_d = ~q_q;
                MODE_SCLR: q_d = '0;
            endcase
        end
    end

    // Clear outranks preset; while either is held the clock edge is ignored,
    // so an interrupted shift or count leaves nothing pending.
    always_ff @(posedge clk or negedge clr_n_i or negedge pr_n_i) begin
        // NOTE: state registers are written with non-blocking assignments so
        // every flop samples pre-edge values.
        if (!clr_n_i) begin
            q_q <= '0;
        end else if (!pr_n_i) begin
            q_q <= PRESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    // The outputs follow the async pins as levels, not just their falling
    // edges: releasing clear while preset is still held shows PRESET_VAL at
    // once, and both held drives q and q_n high together like a 74LS74.
    always_comb begin
        q_o   = q_q;
        q_n_o = ~q_q;
        if (!clr_n_i && !pr_n_i) begin
            q_o   = '1;
            q_n_o = '1;
        end else if (!clr_n_i) begin
            q_o   = '0;
            q_n_o = '1;
        end else if (!pr_n_i) begin
            q_o   = PRESET_VAL;
            q_n_o = ~PRESET_VAL;
        end
    end

    // tc ignores en so a cascaded stage can be gated by it.
    assign tc_o = !async_hold &&
                  ((mode == MODE_INC && (&q_q)) || (mode == MODE_DEC && !(|q_q)));

endmodule

// File: rtl/ttl_univ_reg.sv
// ttl_univ_reg: CHANNELS independent WIDTH-bit universal registers sharing
// clk and clr_n. Channel c occupies bus bits c*WIDTH+i and mode bits c*3+k.
// Ports:
//   clk     rising-edge clock
//   clr_n   async active-low clear of all channels
//   pr_n    per-channel async active-low preset
//   en      per-channel synchronous enable
//   mode    per-channel 3-bit operation select
//   d       parallel load data
//   ser_r   per-channel shift-right serial input
//   ser_l   per-channel shift-left serial input
//   q, q_n  contents and complement outputs
//   tc      per-channel terminal count
module ttl_univ_reg
    import ttl_pkg::*;
#(
    parameter int                WIDTH      = 8,
    parameter int                CHANNELS   = 2,
    parameter logic [WIDTH-1:0]  PRESET_VAL = {WIDTH{1'b1}}
) (
    input  logic                         clk,
    input  logic                         clr_n,
    input  logic [CHANNELS-1:0]          pr_n,
    input  logic [CHANNELS-1:0]          en,
    input  logic [MODE_W*CHANNELS-1:0]   mode,
    input  logic [WIDTH*CHANNELS-1:0]    d,
    input  logic [CHANNELS-1:0]          ser_r,
    input  logic [CHANNELS-1:0]          ser_l,
    output logic [WIDTH*CHANNELS-1:0]    q,
    output logic [WIDTH*CHANNELS-1:0]    q_n,
    output logic [CHANNELS-1:0]          tc
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        ttl_univ_reg_ch #(
            .WIDTH      (WIDTH),
            .PRESET_VAL (PRESET_VAL)
        ) u_ch (
            .clk     (clk),
            .clr_n_i (clr_n),
            .pr_n_i  (pr_n[c]),
            .en_i    (en[c]),
            .mode_i  (mode[c*MODE_W +: MODE_W]),
            .d_i     (d[c*WIDTH +: WIDTH]),
            .ser_r_i (ser_r[c]),
            .ser_l_i (ser_l[c]),
            .q_o     (q[c*WIDTH +: WIDTH]),
            .q_n_o   (q_n[c*WIDTH +: WIDTH]),
            .tc_o    (tc[c])
        );
    end

endmodule

// File: tb/tb_ttl_univ_reg.sv
module tb_ttl_univ_reg;
    import ttl_pkg::*;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [1:0]  pr_n;
    logic [1:0]  en;
    logic [5:0]  mode;
    logic [15:0] d;
    logic [1:0]  ser_r;
    logic [1:0]  ser_l;
    logic [15:0] q;
    logic [15:0] q_n;
    logic [1:0]  tc;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: stored value of each channel as a plain integer 0..255.
    int mq [2];

    ttl_univ_reg #(.WIDTH(8), .CHANNELS(2), .PRESET_VAL(8'hFF)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .pr_n  (pr_n),
        .en    (en),
        .mode  (mode),
        .d     (d),
        .ser_r (ser_r),
        .ser_l (ser_l),
        .q     (q),
        .q_n   (q_n),
        .tc    (tc)
    );

    always #5 clk = ~clk;

    // Next stored value of channel c from the operation table, using arithmetic.
    function automatic int ch_next(int c);
        int v;
        int m;
        v = mq[c];
        m = int'(mode[c*3 +: 3]);
        if (!clr_n) return 0;
        if (!pr_n[c]) return 255;
        if (!en[c]) return v;
        case (m)
            1:       return int'(d[c*8 +: 8]);
            2:       return (ser_r[c] ? 128 : 0) + v / 2;
            3:       return (v * 2) % 256 + (ser_l[c] ? 1 : 0);
            4:       return (v + 1) % 256;
            5:       return (v + 255) % 256;
            6:       return 255 - v;
            7:       return 0;
            default: return v;
        endcase
    endfunction

    // Expected {q, q_n, tc} given the current pins and model state.
    function automatic logic [33:0] exp_all();
        logic [15:0] eq;
        logic [15:0] eqn;
        logic [1:0]  et;
        int          v;
        int          m;
        for (int c = 0; c < 2; c++) begin
            m = int'(mode[c*3 +: 3]);
            if (!clr_n && !pr_n[c]) begin
                eq[c*8 +: 8]  = 8'hFF;
                eqn[c*8 +: 8] = 8'hFF;
            end else begin
                v = !clr_n ? 0 : (!pr_n[c] ? 255 : mq[c]);
                eq[c*8 +: 8]  = 8'(v);
                eqn[c*8 +: 8] = 8'(255 - v);
            end
            et[c] = clr_n && pr_n[c] && ((m == 4 && mq[c] == 255) || (m == 5 && mq[c] == 0));
        end
        return {eq, eqn, et};
    endfunction

    // One rising edge; the model advances with the values sampled at the edge.
    task automatic tick();
        int nx [2];
        for (int c = 0; c < 2; c++) nx[c] = ch_next(c);
        @(posedge clk);
        #1;
        mq = nx;
    endtask

    // Drive the async pins; they act on the model at once.
    task automatic set_async(input logic clr, input logic [1:0] pr);
        clr_n = clr;
        pr_n  = pr;
        #1;
        for (int c = 0; c < 2; c++) begin
            if (!clr) mq[c] = 0;
            else if (!pr[c]) mq[c] = 255;
        end
    endtask

    task automatic set_ch(input int c, input logic e, input logic [2:0] m,
                          input logic [7:0] dv, input logic sr, input logic sl);
        en[c]         = e;
        mode[c*3 +: 3] = m;
        d[c*8 +: 8]   = dv;
        ser_r[c]      = sr;
        ser_l[c]      = sl;
    endtask

    task automatic test_reset();
        en = '0; mode = '0; d = '0; ser_r = '0; ser_l = '0;
        set_async(1'b0, 2'b11);
        n_vec++;
        if ({q, q_n, tc} !== {16'h0000, 16'hFFFF, 2'b00}) begin
            n_err++;
            $display("FAIL reset_values got %h want %h", {q, q_n, tc}, {16'h0000, 16'hFFFF, 2'b00});
        end
        @(negedge clk);
        set_async(1'b1, 2'b11);
        set_ch(0, 1'b1, MODE_LOAD, 8'h5A, 1'b0, 1'b0);
        set_ch(1, 1'b1, MODE_LOAD, 8'hA5, 1'b0, 1'b0);
        tick();
        n_vec++;
        if (q !== 16'hA55A) begin
            n_err++;
            $display("FAIL load_after_release got %h want %h", q, 16'hA55A);
        end
        set_ch(0, 1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0);
        set_ch(1, 1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        set_async(1'b0, 2'b11);
        n_vec++;
        if ({q, q_n, tc} !== exp_all() || q !== 16'h0000) begin
            n_err++;
            $display("FAIL clear_between_edges got %h want %h", {q, q_n, tc}, exp_all());
        end
        set_async(1'b1, 2'b11);
    endtask

    task automatic test_preset_overlap();
        set_ch(0, 1'b1, MODE_LOAD, 8'h12, 1'b0, 1'b0);
        set_ch(1, 1'b1, MODE_LOAD, 8'h3C, 1'b0, 1'b0);
        tick();
        set_ch(0, 1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0);
        set_ch(1, 1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0);
        set_async(1'b1, 2'b10);
        n_vec++;
        if (q !== 16'h3CFF || {q, q_n, tc} !== exp_all()) begin
            n_err++;
            $display("FAIL preset_ch0 got %h want %h", q, 16'h3CFF);
        end
        set_async(1'b0, 2'b10);
        n_vec++;
        if ({q, q_n, tc} !== {16'h00FF, 16'hFFFF, 2'b00}) begin
            n_err++;
            $display("FAIL clear_preset_overlap got %h want %h", {q, q_n, tc}, {16'h00FF, 16'hFFFF, 2'b00});
        end
        set_async(1'b1, 2'b11);
        n_vec++;
        if ({q, q_n} !== {16'h0000, 16'hFFFF}) begin
            n_err++;
            $display("FAIL release_both got %h want %h", {q, q_n}, {16'h0000, 16'hFFFF});
        end
    endtask

    task automatic test_shift();
        set_ch(0, 1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0);
        set_ch(1, 1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0);
        tick();
        set_ch(0, 1'b1, MODE_SHR, 8'h00, 1'b1, 1'b0);
        set_ch(1, 1'b1, MODE_SHL, 8'h00, 1'b1, 1'b0);
        tick();
        n_vec++;
        if (q !== 16'h02C0) begin
            n_err++;
            $display("FAIL shift_first got %h want %h", q, 16'h02C0);
        end
        tick();
        n_vec++;
        if (q !== 16'h04E0 || {q, q_n, tc} !== exp_all()) begin
            n_err++;
            $display("FAIL shift_second got %h want %h", q, 16'h04E0);
        end
    endtask

    task automatic test_count_wrap();
        set_ch(0, 1'b1, MODE_LOAD, 8'hFE, 1'b0, 1'b0);
        set_ch(1, 1'b1, MODE_LOAD, 8'h00, 1'b0, 1'b0);
        tick();
        set_ch(0, 1'b1, MODE_INC, 8'h00, 1'b0, 1'b0);
        set_ch(1, 1'b1, MODE_DEC, 8'h00, 1'b0, 1'b0);
        #1;
        n_vec++;
        if ({q, tc} !== {16'h00FE, 2'b10}) begin
            n_err++;
            $display("FAIL count_start got %h want %h", {q, tc}, {16'h00FE, 2'b10});
        end
        tick();
        n_vec++;
        if ({q, tc} !== {16'hFFFF, 2'b01}) begin
            n_err++;
            $display("FAIL count_tc got %h want %h", {q, tc}, {16'hFFFF, 2'b01});
        end
        tick();
        n_vec++;
        if ({q, tc} !== {16'hFE00, 2'b00} || {q, q_n, tc} !== exp_all()) begin
            n_err++;
            $display("FAIL count_wrap got %h want %h", {q, tc}, {16'hFE00, 2'b00});
        end
    endtask

    task automatic test_enable();
        set_ch(0, 1'b1, MODE_LOAD, 8'h10, 1'b0, 1'b0);
        set_ch(1, 1'b1, MODE_LOAD, 8'h0F, 1'b0, 1'b0);
        tick();
        set_ch(0, 1'b1, MODE_INC, 8'h00, 1'b0, 1'b0);
        set_ch(1, 1'b0, MODE_INV, 8'h00, 1'b0, 1'b0);
        tick();
        n_vec++;
        if (q !== 16'h0F11) begin
            n_err++;
            $display("FAIL enable_gated got %h want %h", q, 16'h0F11);
        end
        en[1] = 1'b1;
        tick();
        n_vec++;
        if (q !== 16'hF012) begin
            n_err++;
            $display("FAIL enable_open got %h want %h", q, 16'hF012);
        end
    endtask

    task automatic test_mid_op_reset();
        set_ch(0, 1'b1, MODE_LOAD, 8'hF0, 1'b0, 1'b0);
        set_ch(1, 1'b1, MODE_LOAD, 8'h0F, 1'b0, 1'b0);
        tick();
        set_ch(0, 1'b1, MODE_SHR, 8'h00, 1'b1, 1'b0);
        set_ch(1, 1'b1, MODE_SHR, 8'h00, 1'b1, 1'b0);
        tick();
        @(negedge clk);
        set_async(1'b0, 2'b11);
        n_vec++;
        if (q !== 16'h0000) begin
            n_err++;
            $display("FAIL mid_shift_clear got %h want %h", q, 16'h0000);
        end
        tick();
        n_vec++;
        if (q !== 16'h0000 || {q, q_n, tc} !== exp_all()) begin
            n_err++;
            $display("FAIL edge_ignored_in_clear got %h want %h", q, 16'h0000);
        end
        @(negedge clk);
        set_async(1'b1, 2'b11);
        tick();
        n_vec++;
        if (q !== 16'h8080) begin
            n_err++;
            $display("FAIL first_edge_after_release got %h want %h", q, 16'h8080);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            en    = 2'($urandom);
            mode  = 6'($urandom);
            d     = 16'($urandom);
            ser_r = 2'($urandom);
            ser_l = 2'($urandom);
            if ($urandom_range(0, 7) == 0) set_async(1'($urandom), 2'($urandom));
            else set_async(1'b1, 2'b11);
            n_vec++;
            if ({q, q_n, tc} !== exp_all()) begin
                n_err++;
                $display("FAIL random_pre[%0d] got %h want %h", i, {q, q_n, tc}, exp_all());
            end
            tick();
            n_vec++;
            if ({q, q_n, tc} !== exp_all()) begin
                n_err++;
                $display("FAIL random_post[%0d] got %h want %h", i, {q, q_n, tc}, exp_all());
            end
        end
    endtask

    initial begin
        test_reset();
        test_preset_overlap();
        test_shift();
        test_count_wrap();
        test_enable();
        test_mid_op_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
